// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 encryptor: top/KSA/PRGA state encodings,
// S-box geometry, the key-byte selector and the printable-range helper.
package arc4_pkg;

  localparam int         KEY_BYTES = 3;
  localparam int         S_SIZE    = 256;
  localparam logic [7:0] LAST_IDX  = 8'(S_SIZE - 1);
  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_PRGA
  } state_e;

  typedef enum logic [2:0] {
    K_IDLE,
    K_INIT,
    K_RDI,
    K_RDJ,
    K_WRI,
    K_WRJ
  } ksa_state_e;

  typedef enum logic [2:0] {
    P_RDL,
    P_WRL,
    P_RDI,
    P_RDJ,
    P_WRI,
    P_WRJ,
    P_RDT,
    P_WRC
  } prga_state_e;

  // Key byte 0 is the most significant byte of the 24-bit key.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    is_printable = (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/arc4_ksa.sv
// S-box fill (256 cycles) then key schedule (4 cycles per index); owns the S port while busy.
// Accepts en only while rdy=1; rdy returns high once the last swap has been written.
module arc4_ksa
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic        in_ksa,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  input  logic [7:0]  s_rddata
);

  ksa_state_e  state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  si_q, si_d;
  logic [1:0]  kidx_q, kidx_d;
  logic [23:0] key_q, key_d;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    kidx_d   = kidx_q;
    key_d    = key_q;
    rdy      = 1'b0;
    in_ksa   = 1'b0;
    s_addr   = 8'h00;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    case (state_q)
      K_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          key_d   = key;
          i_d     = 8'h00;
          state_d = K_INIT;
        end
      end
      K_INIT: begin
        s_addr   = i_q;
        s_wrdata = i_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        if (i_q == LAST_IDX) begin
          j_d     = 8'h00;
          kidx_d  = 2'd0;
          state_d = K_RDI;
        end
      end
      K_RDI: begin
        in_ksa  = 1'b1;
        s_addr  = i_q;
        state_d = K_RDJ;
      end
      K_RDJ: begin
        // s_rddata holds S[i]; the new j is sent straight out as the next read address.
        in_ksa  = 1'b1;
        si_d    = s_rddata;
        j_d     = j_q + s_rddata + key_byte(key_q, kidx_q);
        s_addr  = j_d;
        state_d = K_WRI;
      end
      K_WRI: begin
        in_ksa   = 1'b1;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = K_WRJ;
      end
      K_WRJ: begin
        in_ksa   = 1'b1;
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        kidx_d   = (kidx_q == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx_q + 2'd1;
        state_d  = (i_q == LAST_IDX) ? K_IDLE : K_RDI;
      end
      default: state_d = K_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= K_IDLE;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      si_q    <= 8'h00;
      kidx_q  <= 2'd0;
      key_q   <= 24'h000000;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor top: job FSM plus PRGA (6 cycles per byte); jobs start on en while rdy=1.
// Optional plaintext printable check enabled by macro ARC4_ENC_PTCHECK_EN (pt_err tied 0 otherwise).
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  input  logic [7:0]  s_rddata,
  output logic        pt_err
);

  state_e      state_q, state_d;
  prga_state_e ps_q, ps_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  ptb_q, ptb_d;

  logic        ksa_en, ksa_rdy, ksa_in_ksa, ksa_s_wren;
  logic [7:0]  ksa_s_addr, ksa_s_wrdata;
  logic        p_s_wren;
  logic [7:0]  p_s_addr, p_s_wrdata;
  logic        job_start;

  arc4_ksa u_ksa (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ksa_en),
    .rdy      (ksa_rdy),
    .in_ksa   (ksa_in_ksa),
    .key      (key),
    .s_addr   (ksa_s_addr),
    .s_wrdata (ksa_s_wrdata),
    .s_wren   (ksa_s_wren),
    .s_rddata (s_rddata)
  );

  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    len_d      = len_q;
    k_d        = k_q;
    ptb_d      = ptb_q;
    rdy        = 1'b0;
    ksa_en     = 1'b0;
    job_start  = 1'b0;
    pt_addr    = 8'h00;
    ct_addr    = 8'h00;
    ct_wrdata  = 8'h00;
    ct_wren    = 1'b0;
    p_s_addr   = 8'h00;
    p_s_wrdata = 8'h00;
    p_s_wren   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          ksa_en    = 1'b1;
          job_start = 1'b1;
          state_d   = ST_INIT;
        end
      end
      ST_INIT: begin
        if (ksa_in_ksa) state_d = ST_KSA;
      end
      ST_KSA: begin
        if (ksa_rdy) begin
          state_d = ST_PRGA;
          ps_d    = P_RDL;
          i_d     = 8'h00;
          j_d     = 8'h00;
        end
      end
      ST_PRGA: begin
        case (ps_q)
          P_RDL: begin
            pt_addr = 8'h00;
            ps_d    = P_WRL;
          end
          P_WRL: begin
            ct_addr   = 8'h00;
            ct_wrdata = pt_rddata;
            ct_wren   = 1'b1;
            len_d     = pt_rddata;
            k_d       = 8'd1;
            if (pt_rddata == 8'h00) state_d = ST_IDLE;
            else                    ps_d    = P_RDI;
          end
          P_RDI: begin
            // Plaintext byte k is fetched in parallel with the S[i] read.
            i_d      = i_q + 8'd1;
            p_s_addr = i_d;
            pt_addr  = k_q;
            ps_d     = P_RDJ;
          end
          P_RDJ: begin
            si_d     = s_rddata;
            j_d      = j_q + s_rddata;
            p_s_addr = j_d;
            ptb_d    = pt_rddata;
            ps_d     = P_WRI;
          end
          P_WRI: begin
            sj_d       = s_rddata;
            p_s_addr   = i_q;
            p_s_wrdata = s_rddata;
            p_s_wren   = 1'b1;
            ps_d       = P_WRJ;
          end
          P_WRJ: begin
            p_s_addr   = j_q;
            p_s_wrdata = si_q;
            p_s_wren   = 1'b1;
            ps_d       = P_RDT;
          end
          P_RDT: begin
            p_s_addr = si_q + sj_q;
            ps_d     = P_WRC;
          end
          P_WRC: begin
            ct_addr   = k_q;
            ct_wrdata = ptb_q ^ s_rddata;
            ct_wren   = 1'b1;
            k_d       = k_q + 8'd1;
            if (k_q == len_q) state_d = ST_IDLE;
            else              ps_d    = P_RDI;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_addr   = (state_q == ST_PRGA) ? p_s_addr   : ksa_s_addr;
  assign s_wrdata = (state_q == ST_PRGA) ? p_s_wrdata : ksa_s_wrdata;
  assign s_wren   = (state_q == ST_PRGA) ? p_s_wren   : ksa_s_wren;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ps_q    <= P_RDL;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      si_q    <= 8'h00;
      sj_q    <= 8'h00;
      len_q   <= 8'h00;
      k_q     <= 8'h00;
      ptb_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      len_q   <= len_d;
      k_q     <= k_d;
      ptb_q   <= ptb_d;
    end
  end

`ifdef ARC4_ENC_PTCHECK_EN
  logic pt_err_q, pt_err_d;
  logic pt_chk;

  assign pt_chk = (state_q == ST_PRGA) && (ps_q == P_RDJ);

  always_comb begin
    pt_err_d = pt_err_q;
    if (job_start)                                pt_err_d = 1'b0;
    else if (pt_chk && !is_printable(pt_rddata)) pt_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pt_err_q <= 1'b0;
    else        pt_err_q <= pt_err_d;
  end

  assign pt_err = pt_err_q;
`else
  assign pt_err = 1'b0;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt: memory models, a ct-write scoreboard and an ARC4 reference keystream.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] key = 24'h0;
  logic        rdy;
  logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata, s_addr, s_wrdata, s_rddata;
  logic        ct_wren, s_wren, pt_err;

  logic [7:0]  pt_mem [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  s_mem  [256];
  logic [7:0]  ks     [256];
  logic [15:0] exp_q  [$];

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int idle_viol = 0;

  always #5 clk = ~clk;

  arc4_encrypt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren),
    .s_addr    (s_addr),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .s_rddata  (s_rddata),
    .pt_err    (pt_err)
  );

  always @(posedge clk) begin
    pt_rddata <= pt_mem[pt_addr];
    s_rddata  <= s_mem[s_addr];
    if (s_wren)  s_mem[s_addr]   <= s_wrdata;
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_le(input string tag, input int got, input int bound);
    checks++;
    assert (got <= bound) else begin
      failures++;
      $error("FAIL %s cycles=%0d limit=%0d", tag, got, bound);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ct_wren) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL ct_extra got addr=%0h data=%0h exp=none", ct_addr, ct_wrdata);
      end else begin
        chk("ct_write", {ct_addr, ct_wrdata}, exp_q.pop_front());
      end
    end
    if (rst_n && rdy && (s_wren || ct_wren)) idle_viol++;
  end

  // Reference ARC4 keystream for bytes 1..len.
  function automatic void gen_ks(input logic [23:0] k, input int len);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t;
    int i, j;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + int'(s[n]) + int'(kb[n % 3])) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int n = 1; n <= len; n++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[n] = s[(int'(s[i]) + int'(s[j])) % 256];
    end
  endfunction

  task automatic push_model(input logic [23:0] k, input int len);
    gen_ks(k, len);
    exp_q.push_back({8'h00, 8'(len)});
    for (int n = 1; n <= len; n++) exp_q.push_back({8'(n), pt_mem[n] ^ ks[n]});
  endtask

  task automatic load_printable(input int len);
    pt_mem[0] = 8'(len);
    for (int n = 1; n <= len; n++) pt_mem[n] = 8'($urandom_range(32'h20, 32'h7E));
  endtask

  function automatic logic exp_pt_err(input int len);
    logic e;
    e = 1'b0;
`ifdef ARC4_ENC_PTCHECK_EN
    for (int n = 1; n <= len; n++)
      if (pt_mem[n] < 8'h20 || pt_mem[n] > 8'h7E) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (!rdy && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Runs one job; expected ct writes must already be queued.
  task automatic do_job(input string tag, input logic [23:0] k, input int len);
    int cyc;
    logic e;
    e = exp_pt_err(len);
    wr_count = 0;
    key = k;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    key = ~k;
    chk({tag, "_busy"}, rdy, 1'b0);
    wait_idle(cyc);
    chk_le({tag, "_latency"}, cyc, 256 + 1024 + 8 * len + 8);
    chk({tag, "_wrcount"}, wr_count, len + 1);
    chk({tag, "_qempty"}, exp_q.size(), 0);
    chk({tag, "_pt_err"}, pt_err, e);
  endtask

  task automatic load_vector();
    string s;
    logic [7:0] v [10];
    s = "Plaintext";
    v = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    pt_mem[0] = 8'd9;
    for (int n = 0; n < 9; n++) pt_mem[n + 1] = s[n];
    for (int n = 0; n < 10; n++) exp_q.push_back({8'(n), v[n]});
  endtask

  initial begin
    int cyc, found, lens[3];
    logic [23:0] fkey, rk;
    logic ok;
    logic [7:0] b;

    for (int n = 0; n < 256; n++) begin
      pt_mem[n] = 8'h00;
      ct_mem[n] = 8'h00;
      s_mem[n]  = 8'h00;
      ks[n]     = 8'h00;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {rdy, ct_wren, s_wren, pt_err}, 4'b1000);
    chk("rst_addr", {pt_addr, ct_addr, ct_wrdata, s_addr, s_wrdata}, 40'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_rdy", rdy, 1'b1);

    // Known-answer vector
    load_vector();
    do_job("kat", 24'h4B6579, 9);

    // Zero-length message
    pt_mem[0] = 8'h00;
    exp_q.push_back(16'h0000);
    do_job("len0", 24'h123456, 0);

    // Model-checked jobs including the maximum length
    lens = '{1, 33, 255};
    for (int t = 0; t < 3; t++) begin
      rk = 24'($urandom);
      load_printable(lens[t]);
      push_model(rk, lens[t]);
      do_job("rand", rk, lens[t]);
    end

    // Non-printable byte, then a clean job
    load_printable(12);
    pt_mem[5] = 8'h0A;
    push_model(24'hC0FFEE, 12);
    do_job("ptbad", 24'hC0FFEE, 12);
    load_printable(12);
    push_model(24'hC0FFEE, 12);
    do_job("ptclean", 24'hC0FFEE, 12);

    // Encrypt, then brute-force a small key range on the captured ct
    load_printable(40);
    push_model(24'h000018, 40);
    do_job("crackenc", 24'h000018, 40);
    found = 0;
    fkey = 24'h0;
    for (int kk = 0; kk < 64 && found == 0; kk++) begin
      gen_ks(24'(kk), 40);
      ok = 1'b1;
      for (int n = 1; n <= 40; n++) begin
        b = ct_mem[n] ^ ks[n];
        if (b < 8'h20 || b > 8'h7E) ok = 1'b0;
      end
      if (ok) begin
        found = 1;
        fkey = 24'(kk);
      end
    end
    chk("crack_valid", found, 1);
    chk("crack_key", fkey, 24'h000018);

    // Reset in the middle of KSA, then the known-answer job again
    key = 24'hABCDEF;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {rdy, ct_wren, s_wren}, 3'b100);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_hold", {rdy, ct_wren, s_wren, s_addr}, 11'b100_0000_0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_vector();
    do_job("kat_after_rst", 24'h4B6579, 9);

    // en held high: two back-to-back jobs, each run once
    load_printable(5);
    push_model(24'h0F1E2D, 5);
    push_model(24'h0F1E2D, 5);
    wr_count = 0;
    key = 24'h0F1E2D;
    en = 1'b1;
    @(posedge clk); #1;
    chk("hold_busy", rdy, 1'b0);
    wait_idle(cyc);
    chk_le("hold_lat1", cyc, 256 + 1024 + 8 * 5 + 8);
    chk("hold_wr1", wr_count, 6);
    @(posedge clk); #1;
    chk("hold_reaccept", rdy, 1'b0);
    en = 1'b0;
    wait_idle(cyc);
    chk_le("hold_lat2", cyc, 256 + 1024 + 8 * 5 + 8);
    chk("hold_wr2", wr_count, 12);
    chk("hold_qempty", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_stay_idle", {rdy, wr_count[7:0]}, {1'b1, 8'd12});

    chk("idle_wren", idle_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
